// File: rtl/sc_fifo_gen.sv
// sc_fifo_gen: parametrised single-clock FIFO, plain-RTL storage.
// Occupancy count, thresholds, show-ahead option, error pulses.
module sc_fifo_gen #(
    parameter int DWIDTH        = 8,
    parameter int DEPTH         = 2048,
    parameter int IS_SHOWAHEAD  = 0,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [DWIDTH-1:0] q,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     usedw,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] PLAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CAF    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] CAE    = CW'(AEMPTY_THRESH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_inc;
    logic [PW-1:0] rptr_inc;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Reset wins over both requests in the same cycle.
    assign wr_acc = wrreq && !full && !rst;
    assign rd_acc = rdreq && !empty && !rst;

    // Explicit compare so non-power-of-two depths wrap correctly.
    always_comb begin
        wptr_inc = (wptr == PLAST) ? '0 : wptr + PW'(1);
        rptr_inc = (rptr == PLAST) ? '0 : rptr + PW'(1);
    end

    always_comb begin
        count_nxt = usedw;
        if (rst) begin
            count_nxt = '0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count_nxt = usedw + CW'(1);
                2'b01:   count_nxt = usedw - CW'(1);
                default: count_nxt = usedw;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr_inc;
            if (rd_acc) rptr <= rptr_inc;
        end
    end

    // Flags follow the next-state count so they never lag usedw.
    always_ff @(posedge clock) begin
        usedw        <= count_nxt;
        empty        <= (count_nxt == '0);
        full         <= (count_nxt == CDEPTH);
        almost_full  <= (count_nxt >= CAF);
        almost_empty <= (count_nxt <= CAE);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wrreq && full;
            underflow <= rdreq && empty;
        end
    end

    // Show-ahead keeps q loaded with the head: a write into an
    // empty (or emptying) FIFO bypasses, a pop prefetches the next.
    always_ff @(posedge clock) begin
        if (rst) begin
            q <= '0;
        end else if (IS_SHOWAHEAD != 0) begin
            if (wr_acc && (usedw == '0 ||
                           (usedw == CW'(1) && rd_acc))) begin
                q <= data;
            end else if (rd_acc) begin
                q <= mem[rptr_inc];
            end
        end else if (rd_acc) begin
            q <= mem[rptr];
        end
    end

endmodule

// File: tb/tb_sc_fifo_gen.sv
// tb_sc_fifo_gen: scoreboard bench, queue reference model,
// standard DEPTH=4 instance and show-ahead DEPTH=3 instance.
module tb_sc_fifo_gen;

    typedef struct {
        logic [7:0] q;
        bit         qchk;
        int         usedw;
        bit         empty;
        bit         full;
        bit         af;
        bit         ae;
        bit         ovf;
        bit         unf;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       a_rst, a_wr, a_rd;
    logic [7:0] a_data, a_q;
    logic [2:0] a_usedw;
    logic       a_empty, a_full, a_af, a_ae, a_ovf, a_unf;

    logic       b_rst, b_wr, b_rd;
    logic [7:0] b_data, b_q;
    logic [1:0] b_usedw;
    logic       b_empty, b_full, b_af, b_ae, b_ovf, b_unf;

    sc_fifo_gen #(
        .DWIDTH(8), .DEPTH(4), .IS_SHOWAHEAD(0),
        .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) u_a (
        .clock(clock), .rst(a_rst), .data(a_data),
        .wrreq(a_wr), .rdreq(a_rd), .q(a_q),
        .empty(a_empty), .full(a_full), .usedw(a_usedw),
        .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf)
    );

    sc_fifo_gen #(
        .DWIDTH(8), .DEPTH(3), .IS_SHOWAHEAD(1),
        .AFULL_THRESH(2), .AEMPTY_THRESH(1)
    ) u_b (
        .clock(clock), .rst(b_rst), .data(b_data),
        .wrreq(b_wr), .rdreq(b_rd), .q(b_q),
        .empty(b_empty), .full(b_full), .usedw(b_usedw),
        .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mqa[$];
    logic [7:0] mqb[$];
    logic [7:0] qha = 8'h00;
    logic [7:0] qhb = 8'h00;
    exp_t       sba[$];
    exp_t       sbb[$];

    task automatic cmp(input string t, input string f,
                       input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s got %0d want %0d at %0t",
                     t, f, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words.
    task automatic model_step(input int id, input bit r,
                              input bit w, input bit rd,
                              input logic [7:0] d,
                              output exp_t e);
        logic [7:0] mq[$];
        logic [7:0] qh;
        int  depth, afth, n;
        bit  sa, wok, rok;
        sa    = (id != 0);
        depth = sa ? 3 : 4;
        afth  = sa ? 2 : 3;
        mq    = sa ? mqb : mqa;
        qh    = sa ? qhb : qha;
        wok   = 0;
        rok   = 0;
        if (r) begin
            mq.delete();
            qh = 8'h00;
        end else begin
            n   = mq.size();
            wok = w && (n < depth);
            rok = rd && (n > 0);
            if (rok) qh = mq.pop_front();
            if (wok) mq.push_back(d);
        end
        n       = mq.size();
        e.usedw = n;
        e.empty = (n == 0);
        e.full  = (n == depth);
        e.af    = (n >= afth);
        e.ae    = (n <= 1);
        e.ovf   = !r && w && !wok;
        e.unf   = !r && rd && !rok;
        if (sa && !r) begin
            e.qchk = (n > 0);
            e.q    = (n > 0) ? mq[0] : 8'h00;
        end else begin
            e.qchk = 1;
            e.q    = qh;
        end
        if (sa) begin
            mqb = mq;
            qhb = qh;
        end else begin
            mqa = mq;
            qha = qh;
        end
    endtask

    task automatic drive(input int id, input bit r, input bit w,
                         input bit rd, input logic [7:0] d);
        exp_t e;
        @(negedge clock);
        if (id == 0) begin
            a_rst = r; a_wr = w; a_rd = rd; a_data = d;
        end else begin
            b_rst = r; b_wr = w; b_rd = rd; b_data = d;
        end
        model_step(id, r, w, rd, d, e);
        if (id == 0) sba.push_back(e);
        else         sbb.push_back(e);
    endtask

    task automatic check(input string t, input exp_t e,
                         input logic [7:0] q, input int u,
                         input bit em, input bit fu,
                         input bit af, input bit ae,
                         input bit ov, input bit un);
        cmp(t, "usedw", u, e.usedw);
        cmp(t, "empty", int'(em), int'(e.empty));
        cmp(t, "full", int'(fu), int'(e.full));
        cmp(t, "almost_full", int'(af), int'(e.af));
        cmp(t, "almost_empty", int'(ae), int'(e.ae));
        cmp(t, "overflow", int'(ov), int'(e.ovf));
        cmp(t, "underflow", int'(un), int'(e.unf));
        if (e.qchk) cmp(t, "q", int'(q), int'(e.q));
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sba.size() > 0) begin
            e = sba.pop_front();
            check("std", e, a_q, int'(a_usedw), a_empty, a_full,
                  a_af, a_ae, a_ovf, a_unf);
        end
        if (sbb.size() > 0) begin
            e = sbb.pop_front();
            check("sa", e, b_q, int'(b_usedw), b_empty, b_full,
                  b_af, b_ae, b_ovf, b_unf);
        end
    end

    task automatic rand_run(input int id, input int n,
                            input int wb, input int rb);
        bit r, w, rd;
        for (int i = 0; i < n; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 99) < wb);
            rd = ($urandom_range(0, 99) < rb);
            drive(id, r, w, rd, 8'($urandom));
        end
    endtask

    task automatic mid_reset(input int id);
        drive(id, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) drive(id, 0, 1, 0, 8'(8'h31 + i));
        drive(id, 1, 1, 0, 8'hEE);
        drive(id, 0, 1, 0, 8'h77);
        drive(id, 0, 0, 1, 8'h00);
        drive(id, 0, 0, 0, 8'h00);
    endtask

    task automatic run_a();
        drive(0, 1, 1, 1, 8'hFF);
        drive(0, 1, 1, 1, 8'hFF);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 8'(8'hA1 + i));
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        rand_run(0, 150, 75, 30);
        rand_run(0, 150, 30, 75);
        rand_run(0, 150, 60, 60);
        mid_reset(0);
    endtask

    task automatic run_b();
        drive(1, 1, 1, 1, 8'hFF);
        drive(1, 1, 1, 1, 8'hFF);
        drive(1, 0, 1, 0, 8'h55);
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 1, 1, 8'h66);
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 1, 8'h00);
        drive(1, 0, 0, 1, 8'h00);
        for (int i = 0; i < 10; i++) drive(1, 0, 1, (i >= 2), 8'(i));
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 8'h00);
        rand_run(1, 150, 75, 30);
        rand_run(1, 150, 30, 75);
        rand_run(1, 150, 60, 60);
        mid_reset(1);
    endtask

    initial begin
        a_rst = 1; a_wr = 0; a_rd = 0; a_data = 8'h00;
        b_rst = 1; b_wr = 0; b_rd = 0; b_data = 8'h00;
        fork
            run_a();
            run_b();
        join
        for (int i = 0; i < 10; i++) begin
            if (sba.size() == 0 && sbb.size() == 0) break;
            @(posedge clock);
            #2;
        end
        n_tests++;
        if (sba.size() != 0 || sbb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending %0d/%0d want 0",
                     sba.size(), sbb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_fifo_gen.md
# sc_fifo_gen

Parametrised single-clock FIFO; the next generation of the team's single-clock FIFO wrapper, implemented in plain RTL with no vendor primitive. It adds real occupancy count, synchronous reset, selectable standard/show-ahead read mode, programmable almost-full/almost-empty flags and overflow/underflow error pulses. It is used as the generic buffering element between pipeline stages of the queue data structures.

## Interface
- DWIDTH, 8: data width in bits.
- DEPTH, 2048: number of entries; any integer >= 2, not restricted to powers of two.
- IS_SHOWAHEAD, 0: 0 = standard read, 1 = show-ahead (first-word-fall-through).
- AFULL_THRESH, DEPTH-1: almost_full asserted when usedw >= AFULL_THRESH.
- AEMPTY_THRESH, 1: almost_empty asserted when usedw <= AEMPTY_THRESH.
- Derived: CW = $clog2(DEPTH+1), the count width.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data  in  DWIDTH  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request (standard) / pop acknowledge (show-ahead).
- q  out  DWIDTH  read data.
- empty  out  1  no entries stored.
- full  out  1  DEPTH entries stored.
- usedw  out  CW  current occupancy, 0..DEPTH inclusive.
- almost_full  out  1  usedw >= AFULL_THRESH.
- almost_empty  out  1  usedw <= AEMPTY_THRESH.
- overflow  out  1  one-cycle pulse: previous cycle's wrreq rejected.
- underflow  out  1  one-cycle pulse: previous cycle's rdreq rejected.

## Operation
- Storage: DEPTH x DWIDTH array; write pointer and read pointer each in 0..DEPTH-1, wrapping from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- Write accepted iff wrreq && !full. A write is rejected when full, even if rdreq is asserted in the same cycle.
- Read accepted iff rdreq && !empty. A read is rejected when empty, even if wrreq is asserted in the same cycle.
- Accepted write: data is stored at the write pointer and the write pointer advances. Accepted read: the head entry is consumed and the read pointer advances.
- usedw: +1 on write only, -1 on read only, unchanged when both are accepted.
- Flags are registered and derived from the next-state count: empty = (count==0), full = (count==DEPTH), almost_full and almost_empty per their thresholds. All flags are always consistent with usedw in the same cycle.
- Standard mode: q is registered and loaded with the head entry on an accepted read. q holds its value otherwise, including on a rejected read.
- Show-ahead mode: whenever !empty, q presents the current head entry. An accepted rdreq pops it, and q shows the next entry from the following cycle. q is don't-care while empty.
- overflow/underflow: registered pulses, high for exactly one cycle per rejected request. They are not sticky.
- Stored contents are not cleared by reset.

## Timing
- Reset values (cycle after rst is sampled high): empty=1, full=0, usedw=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, q=0, both pointers 0.
- rst takes priority over wrreq/rdreq in the same cycle. Reset mid-operation discards all entries, and requests in the reset cycle are neither accepted nor flagged.
- Write at edge N: usedw, empty and flags update after edge N. In show-ahead mode, when the FIFO was empty, q = data from edge N onward (write-to-visible latency 1).
- Standard read accepted at edge N: q valid after edge N (read latency 1).
- Simultaneous accepted read and write at usedw==1 in show-ahead mode: q shows the newly written entry after the edge and empty stays 0.
- Back-to-back writes and reads every cycle are sustained at full throughput, with no bubbles.

## Test plan
- Reset: DEPTH=4, hold rst 2 cycles with wrreq=rdreq=1 -> empty=1, full=0, usedw=0, almost_empty=1, overflow=underflow=0, q=0.
- Fill/overflow: DEPTH=4, AFULL_THRESH=3, write 0xA1..0xA5 on consecutive cycles -> usedw 1,2,3,4,4; almost_full from the 3rd write; full after the 4th; overflow pulses once after the 5th; 0xA5 is not stored.
- Drain/underflow, standard mode: read 5 times from the prior state -> q = A1,A2,A3,A4 each one cycle after its rdreq; empty after the 4th read; underflow pulses once; q holds A4.
- Wrap-around, DEPTH=3 (non-power-of-two): 10 cycles of writes 0..9 with reads starting cycle 2 -> output order 0..9 exactly; usedw never exceeds 3.
- Show-ahead: IS_SHOWAHEAD=1, write 0x55 into an empty FIFO -> q=0x55 and empty=0 the next cycle; concurrent rdreq+wrreq(0x66) -> q=0x66, usedw stays 1.
- Mid-operation reset: usedw=3, assert rst one cycle alongside wrreq -> all reset values; next write of 0x77 then read returns 0x77 (stale data never appears).
